// File: rtl/inst_enc_pkg.sv
// Shared MIPS-I encoding constants, FSM state type and mnemonic table for the
// streaming mnemonic encoder (same field values the debug decoder uses).
package inst_enc_pkg;

   typedef enum logic [1:0] {
      ST_IDLE,
      ST_COLLECT,
      ST_LOOKUP,
      ST_OUTPUT
   } state_t;

   localparam int NAME_W = 56;

   localparam logic [5:0] OP_SPECIAL = 6'h00;
   localparam logic [5:0] OP_REGIMM  = 6'h01;
   localparam logic [5:0] OP_J       = 6'h02;
   localparam logic [5:0] OP_JAL     = 6'h03;
   localparam logic [5:0] OP_BEQ     = 6'h04;
   localparam logic [5:0] OP_BNE     = 6'h05;
   localparam logic [5:0] OP_BLEZ    = 6'h06;
   localparam logic [5:0] OP_BGTZ    = 6'h07;
   localparam logic [5:0] OP_ADDI    = 6'h08;
   localparam logic [5:0] OP_ADDIU   = 6'h09;
   localparam logic [5:0] OP_SLTI    = 6'h0A;
   localparam logic [5:0] OP_SLTIU   = 6'h0B;
   localparam logic [5:0] OP_ANDI    = 6'h0C;
   localparam logic [5:0] OP_ORI     = 6'h0D;
   localparam logic [5:0] OP_XORI    = 6'h0E;
   localparam logic [5:0] OP_LUI     = 6'h0F;
   localparam logic [5:0] OP_COP0    = 6'h10;
   localparam logic [5:0] OP_LB      = 6'h20;
   localparam logic [5:0] OP_LH      = 6'h21;
   localparam logic [5:0] OP_LW      = 6'h23;
   localparam logic [5:0] OP_LBU     = 6'h24;
   localparam logic [5:0] OP_LHU     = 6'h25;
   localparam logic [5:0] OP_SB      = 6'h28;
   localparam logic [5:0] OP_SH      = 6'h29;
   localparam logic [5:0] OP_SW      = 6'h2B;

   localparam logic [5:0] FN_SLL     = 6'h00;
   localparam logic [5:0] FN_SRL     = 6'h02;
   localparam logic [5:0] FN_SRA     = 6'h03;
   localparam logic [5:0] FN_SLLV    = 6'h04;
   localparam logic [5:0] FN_SRLV    = 6'h06;
   localparam logic [5:0] FN_SRAV    = 6'h07;
   localparam logic [5:0] FN_JR      = 6'h08;
   localparam logic [5:0] FN_JALR    = 6'h09;
   localparam logic [5:0] FN_SYSCALL = 6'h0C;
   localparam logic [5:0] FN_BREAK   = 6'h0D;
   localparam logic [5:0] FN_MFHI    = 6'h10;
   localparam logic [5:0] FN_MTHI    = 6'h11;
   localparam logic [5:0] FN_MFLO    = 6'h12;
   localparam logic [5:0] FN_MTLO    = 6'h13;
   localparam logic [5:0] FN_MULT    = 6'h18;
   localparam logic [5:0] FN_MULTU   = 6'h19;
   localparam logic [5:0] FN_DIV     = 6'h1A;
   localparam logic [5:0] FN_DIVU    = 6'h1B;
   localparam logic [5:0] FN_ADD     = 6'h20;
   localparam logic [5:0] FN_ADDU    = 6'h21;
   localparam logic [5:0] FN_SUB     = 6'h22;
   localparam logic [5:0] FN_SUBU    = 6'h23;
   localparam logic [5:0] FN_AND     = 6'h24;
   localparam logic [5:0] FN_OR      = 6'h25;
   localparam logic [5:0] FN_XOR     = 6'h26;
   localparam logic [5:0] FN_NOR     = 6'h27;
   localparam logic [5:0] FN_SLT     = 6'h2A;
   localparam logic [5:0] FN_SLTU    = 6'h2B;

   localparam logic [4:0] RT_BLTZ    = 5'h00;
   localparam logic [4:0] RT_BGEZ    = 5'h01;
   localparam logic [4:0] RT_BLTZAL  = 5'h10;
   localparam logic [4:0] RT_BGEZAL  = 5'h11;

   localparam logic [4:0] C0_MF      = 5'h00;
   localparam logic [4:0] C0_MT      = 5'h04;
   localparam logic [4:0] C0_CO      = 5'h10;
   localparam logic [5:0] FN_ERET    = 6'h18;

   function automatic logic [31:0] r_type(input logic [5:0] funct);
      return {OP_SPECIAL, 20'd0, funct};
   endfunction

   function automatic logic [31:0] op_only(input logic [5:0] op);
      return {op, 26'd0};
   endfunction

   function automatic logic [31:0] regimm(input logic [4:0] rt);
      return {OP_REGIMM, 5'd0, rt, 16'd0};
   endfunction

   function automatic logic [31:0] cop0(input logic [4:0] rs, input logic [5:0] funct);
      return {OP_COP0, rs, 15'd0, funct};
   endfunction

   typedef struct packed {
      logic [NAME_W-1:0] name;
      logic [31:0]       instr;
   } lut_entry_t;

   // Names are right-aligned and zero-padded, matching the collect buffer layout.
   localparam int LUT_N = 58;
   localparam lut_entry_t LUT_TABLE [LUT_N] = '{
      '{56'("AND"),     r_type(FN_AND)},
      '{56'("OR"),      r_type(FN_OR)},
      '{56'("XOR"),     r_type(FN_XOR)},
      '{56'("NOR"),     r_type(FN_NOR)},
      '{56'("SLL"),     r_type(FN_SLL)},
      '{56'("SRL"),     r_type(FN_SRL)},
      '{56'("SRA"),     r_type(FN_SRA)},
      '{56'("SLLV"),    r_type(FN_SLLV)},
      '{56'("SRLV"),    r_type(FN_SRLV)},
      '{56'("SRAV"),    r_type(FN_SRAV)},
      '{56'("MFHI"),    r_type(FN_MFHI)},
      '{56'("MTHI"),    r_type(FN_MTHI)},
      '{56'("MFLO"),    r_type(FN_MFLO)},
      '{56'("MTLO"),    r_type(FN_MTLO)},
      '{56'("ADD"),     r_type(FN_ADD)},
      '{56'("ADDU"),    r_type(FN_ADDU)},
      '{56'("SUB"),     r_type(FN_SUB)},
      '{56'("SUBU"),    r_type(FN_SUBU)},
      '{56'("SLT"),     r_type(FN_SLT)},
      '{56'("SLTU"),    r_type(FN_SLTU)},
      '{56'("MULT"),    r_type(FN_MULT)},
      '{56'("MULTU"),   r_type(FN_MULTU)},
      '{56'("DIV"),     r_type(FN_DIV)},
      '{56'("DIVU"),    r_type(FN_DIVU)},
      '{56'("JR"),      r_type(FN_JR)},
      '{56'("JALR"),    r_type(FN_JALR)},
      '{56'("SYSCALL"), r_type(FN_SYSCALL)},
      '{56'("BREAK"),   r_type(FN_BREAK)},
      '{56'("ANDI"),    op_only(OP_ANDI)},
      '{56'("XORI"),    op_only(OP_XORI)},
      '{56'("LUI"),     op_only(OP_LUI)},
      '{56'("ORI"),     op_only(OP_ORI)},
      '{56'("ADDI"),    op_only(OP_ADDI)},
      '{56'("ADDIU"),   op_only(OP_ADDIU)},
      '{56'("SLTI"),    op_only(OP_SLTI)},
      '{56'("SLTIU"),   op_only(OP_SLTIU)},
      '{56'("J"),       op_only(OP_J)},
      '{56'("JAL"),     op_only(OP_JAL)},
      '{56'("BEQ"),     op_only(OP_BEQ)},
      '{56'("BNE"),     op_only(OP_BNE)},
      '{56'("BGTZ"),    op_only(OP_BGTZ)},
      '{56'("BLEZ"),    op_only(OP_BLEZ)},
      '{56'("LB"),      op_only(OP_LB)},
      '{56'("LBU"),     op_only(OP_LBU)},
      '{56'("LH"),      op_only(OP_LH)},
      '{56'("LHU"),     op_only(OP_LHU)},
      '{56'("LW"),      op_only(OP_LW)},
      '{56'("SB"),      op_only(OP_SB)},
      '{56'("SH"),      op_only(OP_SH)},
      '{56'("SW"),      op_only(OP_SW)},
      '{56'("BGEZ"),    regimm(RT_BGEZ)},
      '{56'("BLTZ"),    regimm(RT_BLTZ)},
      '{56'("BGEZAL"),  regimm(RT_BGEZAL)},
      '{56'("BLTZAL"),  regimm(RT_BLTZAL)},
      '{56'("MFC0"),    cop0(C0_MF, 6'h00)},
      '{56'("MTC0"),    cop0(C0_MT, 6'h00)},
      '{56'("ERET"),    cop0(C0_CO, FN_ERET)},
      '{56'("NOP"),     32'h0000_0000}
   };

endpackage

// File: rtl/inst_enc_lut.sv
// Combinational mnemonic lookup: maps a right-aligned, zero-padded token to
// {hit, instruction skeleton}.
module inst_enc_lut
   import inst_enc_pkg::*;
#(
   parameter int MAX_LEN = 7
) (
   input  logic [8*MAX_LEN-1:0] token,
   output logic                 hit,
   output logic [31:0]          instr
);

   localparam int TW = 8 * MAX_LEN;
   localparam int CW = (TW > NAME_W) ? TW : NAME_W;

   logic [CW-1:0] tok_ext;

   assign tok_ext = CW'(token);

   always_comb begin
      hit   = 1'b0;
      instr = 32'd0;
      for (int i = 0; i < LUT_N; i++) begin
         if (tok_ext == CW'(LUT_TABLE[i].name)) begin
            hit   = 1'b1;
            instr = LUT_TABLE[i].instr;
         end
      end
   end

endmodule

// File: rtl/inst_enc.sv
// Streaming MIPS mnemonic encoder: collects one ASCII token and emits its
// instruction skeleton. Define INST_ENC_LOWER_EN to accept lowercase a-z.
module inst_enc
   import inst_enc_pkg::*;
#(
   parameter int MAX_LEN = 7
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic [7:0]  in_char,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [31:0] out_instr,
   output logic        out_err
);

   localparam int TW = 8 * MAX_LEN;
   localparam int LW = $clog2(MAX_LEN + 2);
   localparam logic [LW-1:0] LEN_FULL = LW'(MAX_LEN);
   localparam logic [LW-1:0] LEN_OVF  = LW'(MAX_LEN + 1);

   state_t          state;
   state_t          next_state;
   logic [TW-1:0]   tok_buf;
   logic [LW-1:0]   len;
   logic            bad;
   logic            ovf;
   logic [7:0]      ch;
   logic            is_delim;
   logic            is_legal;
   logic            xfer;
   logic            lut_hit;
   logic [31:0]     lut_instr;
   logic            lut_err;

   // Delimiters are judged on the raw byte; legality on the (optionally folded) byte.
   always_comb begin
      ch = in_char;
`ifdef INST_ENC_LOWER_EN
      if (in_char >= 8'h61 && in_char <= 8'h7A) begin
         ch = in_char - 8'h20;
      end
`else
`endif
      is_delim = (in_char == 8'h20) || (in_char == 8'h0A) || (in_char == 8'h0D);
      is_legal = (ch >= 8'h41 && ch <= 8'h5A) || (ch >= 8'h30 && ch <= 8'h39);
   end

   assign xfer = in_valid && in_ready;

   inst_enc_lut #(.MAX_LEN(MAX_LEN)) u_lut (
      .token (tok_buf),
      .hit   (lut_hit),
      .instr (lut_instr)
   );

   assign lut_err = bad || ovf || !lut_hit;

   always_ff @(posedge clk) begin
      if (rst) begin
         state <= ST_IDLE;
      end else begin
         state <= next_state;
      end
   end

   always_comb begin
      next_state = state;
      in_ready   = 1'b0;
      out_valid  = 1'b0;
      case (state)
         ST_IDLE: begin
            in_ready = 1'b1;
            if (in_valid && !is_delim) begin
               next_state = ST_COLLECT;
            end
         end
         ST_COLLECT: begin
            in_ready = 1'b1;
            if (in_valid && is_delim) begin
               next_state = ST_LOOKUP;
            end
         end
         ST_LOOKUP: begin
            next_state = ST_OUTPUT;
         end
         ST_OUTPUT: begin
            out_valid = 1'b1;
            if (out_ready) begin
               next_state = ST_IDLE;
            end
         end
         default: begin
            next_state = ST_IDLE;
         end
      endcase
      if (rst) begin
         in_ready = 1'b0;
      end
   end

   // Once the token overflows, the buffer freezes and later characters only keep len saturated.
   always_ff @(posedge clk) begin
      if (rst) begin
         tok_buf   <= '0;
         len       <= '0;
         bad       <= 1'b0;
         ovf       <= 1'b0;
         out_instr <= 32'd0;
         out_err   <= 1'b0;
      end else begin
         case (state)
            ST_IDLE: begin
               if (xfer && !is_delim) begin
                  tok_buf <= TW'(ch);
                  len     <= LW'(1);
                  bad     <= !is_legal;
                  ovf     <= 1'b0;
               end
            end
            ST_COLLECT: begin
               if (xfer && !is_delim) begin
                  bad <= bad || !is_legal;
                  if (len < LEN_FULL) begin
                     tok_buf <= {tok_buf[TW-9:0], ch};
                     len     <= len + LW'(1);
                  end else begin
                     len <= LEN_OVF;
                     ovf <= 1'b1;
                  end
               end
            end
            ST_LOOKUP: begin
               out_err   <= lut_err;
               out_instr <= lut_err ? 32'd0 : lut_instr;
            end
            ST_OUTPUT: begin
               if (out_ready) begin
                  tok_buf <= '0;
                  len     <= '0;
                  bad     <= 1'b0;
                  ovf     <= 1'b0;
               end
            end
            default: begin
            end
         endcase
      end
   end

endmodule
